// File: rtl/ps2_frame_rx_pkg.sv
// Shared types for the PS/2 receive path: frame FSM states and the buffered key event.
package ps2_pkg;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;

    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } ps2_event_t;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_REL = 8'hF0;

    // Odd parity: the data bits together with the parity bit hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Small synchronous FIFO of key events; extra pointer MSB tells full from empty.
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push_i,
    input  logic       pop_i,
    input  ps2_event_t data_i,
    output ps2_event_t data_o,
    output logic       empty_o,
    output logic       full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0] wr_ptr_q, rd_ptr_q;
    ps2_event_t  mem_q [DEPTH];
    logic        do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i & ~empty_o;
    // A pop frees the head slot in the same cycle, so a full FIFO still takes the push.
    assign do_push = push_i & (~full_o | do_pop);
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin sync, clock debounce, frame FSM with timeout, prefix folding, event FIFO.
//  state  | meaning
//  IDLE   | waiting for a start bit (data low on a clock fall)
//  DATA   | shifting 8 data bits, LSB first
//  PARITY | capturing the parity bit
//  STOP   | checking parity and stop bit, decoding the byte
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] ev_code,
    output logic       ev_release,
    output logic       ev_extended,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       timeout_err,
    output logic       overflow,
    input  logic       clear_ovf
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [FW-1:0] FILT_ONE  = FW'(1);
    localparam logic [TW-1:0] TMO_LOAD  = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_ONE   = TW'(1);

    logic [1:0]    clk_s_q, dat_s_q;
    logic          filt_q, filt_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    ps2_state_t    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          ext_q, ext_d, rel_q, rel_d;
    logic          perr_q, perr_d, ferr_q, ferr_d, terr_q, terr_d;
    logic          ovf_q, ovf_d;
    logic          fall, data_bit, push, pop, fifo_empty, fifo_full;
    ps2_event_t    ev_in, ev_head;

    // Filtered level only flips after FILTER_LEN consecutive differing samples.
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_s_q[1] != filt_q) begin
            if (filt_cnt_q == FILT_LAST) filt_d = clk_s_q[1];
            else                         filt_cnt_d = filt_cnt_q + FILT_ONE;
        end
    end

    assign fall     = filt_q & ~filt_d;
    assign data_bit = dat_s_q[1];

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        timer_d   = timer_q;
        ext_d     = ext_q;
        rel_d     = rel_q;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        terr_d    = 1'b0;
        push      = 1'b0;
        if (state_q == IDLE) begin
            timer_d = '0;
            if (fall && !data_bit) begin
                state_d   = DATA;
                bit_cnt_d = '0;
                timer_d   = TMO_LOAD;
            end
        end else if (fall) begin
            timer_d = TMO_LOAD;
            case (state_q)
                DATA: begin
                    shift_d   = {data_bit, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = data_bit;
                    state_d = STOP;
                end
                default: begin
                    state_d = IDLE;
                    timer_d = '0;
                    if (!odd_parity_ok(shift_q, par_q)) perr_d = 1'b1;
                    else if (!data_bit)                 ferr_d = 1'b1;
                    else if (shift_q == PS2_PREFIX_EXT) ext_d  = 1'b1;
                    else if (shift_q == PS2_PREFIX_REL) rel_d  = 1'b1;
                    else begin
                        push  = 1'b1;
                        ext_d = 1'b0;
                        rel_d = 1'b0;
                    end
                end
            endcase
        end else if (timer_q <= TMO_ONE) begin
            state_d = IDLE;
            timer_d = '0;
            terr_d  = 1'b1;
        end else begin
            timer_d = timer_q - TMO_ONE;
        end
    end

    assign ev_in.ext  = ext_q;
    assign ev_in.rel  = rel_q;
    assign ev_in.code = shift_q;
    assign pop        = ev_valid & ev_ready;

    // A same-cycle drop beats clear_ovf.
    always_comb begin
        ovf_d = ovf_q;
        if (push && fifo_full && !pop) ovf_d = 1'b1;
        else if (clear_ovf)            ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_s_q    <= 2'b11;
            dat_s_q    <= 2'b11;
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            timer_q    <= '0;
            ext_q      <= 1'b0;
            rel_q      <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            terr_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            clk_s_q    <= {clk_s_q[0], ps2_clk};
            dat_s_q    <= {dat_s_q[0], ps2_data};
            filt_q     <= filt_d;
            filt_cnt_q <= filt_cnt_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            timer_q    <= timer_d;
            ext_q      <= ext_d;
            rel_q      <= rel_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            terr_q     <= terr_d;
            ovf_q      <= ovf_d;
        end
    end

    ps2_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (ev_in),
        .data_o  (ev_head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign ev_valid    = ~fifo_empty;
    assign ev_code     = ev_valid ? ev_head.code : 8'h00;
    assign ev_release  = ev_valid & ev_head.rel;
    assign ev_extended = ev_valid & ev_head.ext;
    assign parity_err  = perr_q;
    assign frame_err   = ferr_q;
    assign timeout_err = terr_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Directed bench for ps2_frame_rx: table of single frames plus hand-written timeout/overflow/reset sequences.
module tb_ps2_frame_rx;
    import ps2_pkg::*;

    localparam int HALF    = 20;
    localparam int TIMEOUT = 5000;

    logic       clk = 1'b0;
    logic       reset, ps2_clk, ps2_data, ev_ready, clear_ovf;
    logic [7:0] ev_code;
    logic       ev_release, ev_extended, ev_valid;
    logic       parity_err, frame_err, timeout_err, overflow;

    int checks   = 0;
    int failures = 0;
    int perr_cnt = 0;
    int ferr_cnt = 0;
    int terr_cnt = 0;

    ps2_frame_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TIMEOUT), .FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .ev_code     (ev_code),
        .ev_release  (ev_release),
        .ev_extended (ev_extended),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .timeout_err (timeout_err),
        .overflow    (overflow),
        .clear_ovf   (clear_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (parity_err)  perr_cnt <= perr_cnt + 1;
        if (frame_err)   ferr_cnt <= ferr_cnt + 1;
        if (timeout_err) terr_cnt <= terr_cnt + 1;
    end

    typedef struct {
        logic [7:0] code;
        logic       bad_par;
        logic       stop;
        logic       exp_valid;
        logic [7:0] exp_code;
        logic       exp_rel;
        logic       exp_ext;
        int         exp_perr;
        int         exp_ferr;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        @(negedge clk) ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code, input logic bad_par, input logic stop);
        logic par;
        par = (~^code) ^ bad_par;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(code[i]);
        ps2_bit(par);
        ps2_bit(stop);
        @(negedge clk) ps2_data = 1'b1;
        repeat (30) @(negedge clk);
    endtask

    task automatic pop_one();
        @(negedge clk) ev_ready = 1'b1;
        @(negedge clk) ev_ready = 1'b0;
    endtask

    initial begin
        int p0, f0, t0;

        vecs[0]  = '{8'h1D, 1'b0, 1'b1, 1'b1, 8'h1D, 1'b0, 1'b0, 0, 0};
        vecs[1]  = '{8'hF0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0, 0};
        vecs[2]  = '{8'h1D, 1'b0, 1'b1, 1'b1, 8'h1D, 1'b1, 1'b0, 0, 0};
        vecs[3]  = '{8'hE0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0, 0};
        vecs[4]  = '{8'hF0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0, 0};
        vecs[5]  = '{8'h75, 1'b0, 1'b1, 1'b1, 8'h75, 1'b1, 1'b1, 0, 0};
        vecs[6]  = '{8'h1D, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1, 0};
        vecs[7]  = '{8'h1D, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0, 1};
        vecs[8]  = '{8'h1D, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1, 0};
        vecs[9]  = '{8'hE0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0, 0};
        vecs[10] = '{8'h1D, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1, 0};
        vecs[11] = '{8'h6B, 1'b0, 1'b1, 1'b1, 8'h6B, 1'b0, 1'b1, 0, 0};

        reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; ev_ready = 1'b0; clear_ovf = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_valid", 32'(ev_valid), 32'd0);
        check("rst_code", 32'(ev_code), 32'd0);
        check("rst_errs", 32'({parity_err, frame_err, timeout_err, overflow}), 32'd0);
        check("rst_state", 32'(dut.state_q), 32'(IDLE));
        @(negedge clk) reset = 1'b0;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            p0 = perr_cnt; f0 = ferr_cnt;
            send_frame(vecs[i].code, vecs[i].bad_par, vecs[i].stop);
            check($sformatf("v%0d_valid", i), 32'(ev_valid), 32'(vecs[i].exp_valid));
            check($sformatf("v%0d_code", i), 32'(ev_code), 32'(vecs[i].exp_code));
            check($sformatf("v%0d_rel", i), 32'(ev_release), 32'(vecs[i].exp_rel));
            check($sformatf("v%0d_ext", i), 32'(ev_extended), 32'(vecs[i].exp_ext));
            check($sformatf("v%0d_perr", i), 32'(perr_cnt - p0), 32'(vecs[i].exp_perr));
            check($sformatf("v%0d_ferr", i), 32'(ferr_cnt - f0), 32'(vecs[i].exp_ferr));
            if (vecs[i].exp_valid) begin
                repeat (5) @(negedge clk);
                check($sformatf("v%0d_hold", i), 32'(ev_code), 32'(vecs[i].exp_code));
                pop_one();
                check($sformatf("v%0d_popped", i), 32'(ev_valid), 32'd0);
            end
        end

        // Timeout: start bit plus four data bits, then the bus goes quiet.
        t0 = terr_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        @(negedge clk) ps2_data = 1'b1;
        repeat (TIMEOUT + 100) @(negedge clk);
        check("tmo_pulse", 32'(terr_cnt - t0), 32'd1);
        check("tmo_state", 32'(dut.state_q), 32'(IDLE));
        check("tmo_noev", 32'(ev_valid), 32'd0);
        send_frame(8'h1C, 1'b0, 1'b1);
        check("tmo_next_valid", 32'(ev_valid), 32'd1);
        check("tmo_next_code", 32'({ev_extended, ev_release, ev_code}), 32'h01C);
        pop_one();

        // Overflow: five frames into a four-entry FIFO with the consumer stalled.
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b1);
        check("ovf_set", 32'(overflow), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("ovf_valid%0d", i), 32'(ev_valid), 32'd1);
            check($sformatf("ovf_order%0d", i), 32'(ev_code), 32'(i));
            pop_one();
        end
        check("ovf_empty", 32'(ev_valid), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);
        @(negedge clk) clear_ovf = 1'b1;
        @(negedge clk) clear_ovf = 1'b0;
        check("ovf_clear", 32'(overflow), 32'd0);

        // Reset mid-frame with one event still buffered.
        send_frame(8'h33, 1'b0, 1'b1);
        check("rmf_pre_valid", 32'(ev_valid), 32'd1);
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(1'b0);
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        check("rmf_valid", 32'(ev_valid), 32'd0);
        check("rmf_code", 32'(ev_code), 32'd0);
        check("rmf_state", 32'(dut.state_q), 32'(IDLE));
        reset = 1'b0;
        ps2_data = 1'b1;
        repeat (40) @(negedge clk);
        send_frame(8'h2B, 1'b0, 1'b1);
        check("rmf_next_valid", 32'(ev_valid), 32'd1);
        check("rmf_next_code", 32'({ev_extended, ev_release, ev_code}), 32'h02B);
        pop_one();
        check("rmf_single", 32'(ev_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
